// File: rtl/int_vector_responder_if.sv
// Interrupt handshake bundle between the CPU side (master) and the vector responder (slave).
interface int_vector_responder_if #(parameter int NUM_SRC = 4);
  logic [NUM_SRC-1:0] irq_req;
  logic               nM1;
  logic               nIORQ;
  logic               nRD;
  logic [7:0]         db_in;
  logic               cfg_we;
  logic [7:0]         cfg_data;
  logic               nINT;
  logic [7:0]         db_out;
  logic               db_oe;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] in_service;

  modport master (
    output irq_req, nM1, nIORQ, nRD, db_in, cfg_we, cfg_data,
    input  nINT, db_out, db_oe, pending, in_service
  );

  modport slave (
    input  irq_req, nM1, nIORQ, nRD, db_in, cfg_we, cfg_data,
    output nINT, db_out, db_oe, pending, in_service
  );
endinterface

// File: rtl/int_vector_responder.sv
// IM2 interrupt responder: latches device requests, answers the acknowledge cycle with a
// priority vector and retires in-service sources when the CPU fetches RETI (ED 4D).
module int_vector_responder #(
  parameter int         NUM_SRC  = 4,
  parameter logic [7:0] SPUR_VEC = 8'hFF
) (
  input logic                  clk,
  input logic                  nreset,
  int_vector_responder_if.slave bus
);
  typedef enum logic {IDLE, SAW_ED} reti_st_t;

  logic [NUM_SRC-1:0] irq_q, pending, in_service, eligible, rise, ack_clr, reti_clr, isv_low;
  logic [7:0]         vec_base, vector, db_out_r;
  logic [2:0]         win;
  logic               ack, ack_done, take, fetch, sample, m1_done, any_elig, blk;
  logic               nint_r, db_oe_r, reti_hit;
  reti_st_t           state, state_nx;

  assign ack    = ~bus.nM1 & ~bus.nIORQ;
  assign fetch  = ~bus.nM1 & ~bus.nRD & bus.nIORQ;
  assign sample = fetch & ~m1_done;
  assign rise   = bus.irq_req & ~irq_q;
  assign take   = ack & ~ack_done;

  // A source is masked by any in-service source of equal or higher priority.
  always_comb begin
    blk      = 1'b0;
    eligible = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      blk         = blk | in_service[i];
      eligible[i] = pending[i] & ~blk;
    end
  end

  always_comb begin
    win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (eligible[i]) win = i[2:0];
  end

  assign any_elig = |eligible;
  assign vector   = vec_base + {4'b0, win, 1'b0};

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_SRC; i++)
      ack_clr[i] = take & any_elig & (win == i[2:0]);
  end

  assign isv_low  = in_service & (~in_service + 1'b1);
  assign reti_clr = reti_hit ? isv_low : '0;

  // RETI detector, advanced only by the first opcode sample of each M1 cycle
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) state <= IDLE;
    else         state <= state_nx;

  always_comb begin
    state_nx = state;
    if (sample)
      case (state)
        IDLE:    state_nx = (bus.db_in == 8'hED) ? SAW_ED : IDLE;
        SAW_ED:  state_nx = (bus.db_in == 8'hED) ? SAW_ED : IDLE;
        default: state_nx = IDLE;
      endcase
  end

  always_comb begin
    reti_hit = 1'b0;
    if (state == SAW_ED && sample && bus.db_in == 8'h4D) reti_hit = 1'b1;
  end

  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      irq_q      <= '0;
      pending    <= '0;
      in_service <= '0;
      vec_base   <= '0;
      nint_r     <= 1'b1;
      db_out_r   <= '0;
      db_oe_r    <= 1'b0;
      ack_done   <= 1'b0;
      m1_done    <= 1'b0;
    end else begin
      irq_q      <= bus.irq_req;
      pending    <= (pending & ~ack_clr) | rise;
      in_service <= (in_service | ack_clr) & ~reti_clr;
      nint_r     <= ~any_elig;
      if (bus.cfg_we) vec_base <= {bus.cfg_data[7:1], 1'b0};
      // ack_done is set even on a spurious ack so the byte stays frozen for the whole cycle
      if (take) begin
        db_out_r <= any_elig ? vector : SPUR_VEC;
        db_oe_r  <= 1'b1;
        ack_done <= 1'b1;
      end else if (!ack) begin
        db_oe_r  <= 1'b0;
        ack_done <= 1'b0;
      end
      if (bus.nM1)     m1_done <= 1'b0;
      else if (sample) m1_done <= 1'b1;
    end

  assign bus.nINT       = nint_r;
  assign bus.db_out     = db_out_r;
  assign bus.db_oe      = db_oe_r;
  assign bus.pending    = pending;
  assign bus.in_service = in_service;
endmodule

// File: tb/tb_int_vector_responder.sv
// Bench for int_vector_responder: table of single-source acknowledges plus nested/RETI/reset sequences.
module tb_int_vector_responder;
  localparam int N = 4;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  int_vector_responder_if #(.NUM_SRC(N)) bif ();
  int_vector_responder #(.NUM_SRC(N), .SPUR_VEC(8'hFF)) dut (
    .clk   (clk),
    .nreset(nreset),
    .bus   (bif.slave)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] sb[$];

  typedef struct {
    int         src;
    logic [7:0] base;
    logic [7:0] vec;
  } vec_rec_t;
  vec_rec_t tbl[5];

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bif.nM1 = 1'b1; bif.nIORQ = 1'b1; bif.nRD = 1'b1;
    bif.db_in = 8'h00; bif.cfg_we = 1'b0; bif.cfg_data = 8'h00;
  endtask

  task automatic do_reset();
    idle_bus();
    bif.irq_req = '0;
    nreset = 1'b0;
    tick(); tick();
    nreset = 1'b1;
    tick();
  endtask

  task automatic set_base(logic [7:0] b);
    bif.cfg_we = 1'b1; bif.cfg_data = b;
    tick();
    bif.cfg_we = 1'b0;
  endtask

  task automatic raise(int idx);
    bif.irq_req[idx] = 1'b1;
    tick(); tick();
  endtask

  // Acknowledge cycle: wait (bounded) for db_oe, compare with the scoreboard head, check hold and release.
  task automatic do_ack(string nm);
    int n = 0;
    logic [7:0] e = 8'h00;
    bif.nM1 = 1'b0; bif.nIORQ = 1'b0;
    do begin tick(); n++; end while (!bif.db_oe && n < 4);
    check({nm, " oe"}, bif.db_oe, 1);
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s sb: got %0h expected queued vector", nm, bif.db_out);
    end else begin
      e = sb.pop_front();
      check({nm, " vec"}, bif.db_out, e);
    end
    tick();
    check({nm, " hold"}, bif.db_out, e);
    bif.nM1 = 1'b1; bif.nIORQ = 1'b1;
    tick();
    check({nm, " release"}, bif.db_oe, 0);
  endtask

  task automatic fetch(logic [7:0] b);
    bif.nM1 = 1'b0; bif.nRD = 1'b0; bif.db_in = b;
    tick(); tick();
    bif.nM1 = 1'b1; bif.nRD = 1'b1; bif.db_in = 8'h00;
    tick();
  endtask

  task automatic io_read(logic [7:0] b);
    bif.nRD = 1'b0; bif.db_in = b;
    tick();
    bif.nRD = 1'b1; bif.db_in = 8'h00;
    tick();
  endtask

  task automatic reti();
    fetch(8'hED);
    fetch(8'h4D);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{src: 2, base: 8'h40, vec: 8'h44};
    tbl[1] = '{src: 0, base: 8'h40, vec: 8'h40};
    tbl[2] = '{src: 3, base: 8'hFE, vec: 8'h04};
    tbl[3] = '{src: 1, base: 8'h81, vec: 8'h82};
    tbl[4] = '{src: 3, base: 8'h80, vec: 8'h86};

    do_reset();
    check("rst nINT", bif.nINT, 1);
    check("rst db_oe", bif.db_oe, 0);
    check("rst db_out", bif.db_out, 0);
    check("rst pending", bif.pending, 0);
    check("rst in_service", bif.in_service, 0);

    for (int k = 0; k < 5; k++) begin
      do_reset();
      set_base(tbl[k].base);
      raise(tbl[k].src);
      check($sformatf("t%0d nINT low", k), bif.nINT, 0);
      sb.push_back(tbl[k].vec);
      do_ack($sformatf("t%0d", k));
      check($sformatf("t%0d in_service", k), bif.in_service, 32'(1) << tbl[k].src);
      check($sformatf("t%0d pending", k), bif.pending, 0);
      check($sformatf("t%0d nINT high", k), bif.nINT, 1);
      reti();
      check($sformatf("t%0d reti", k), bif.in_service, 0);
    end

    // two simultaneous requests; the lower-priority one waits for RETI
    do_reset();
    set_base(8'h80);
    bif.irq_req = 4'b1010;
    tick(); tick();
    check("dual nINT", bif.nINT, 0);
    sb.push_back(8'h82);
    do_ack("dual a1");
    check("dual isv1", bif.in_service, 4'b0010);
    check("dual pend", bif.pending, 4'b1000);
    check("dual blocked", bif.nINT, 1);
    reti();
    check("dual reti", bif.in_service, 0);
    check("dual nINT2", bif.nINT, 0);
    sb.push_back(8'h86);
    do_ack("dual a2");
    check("dual isv3", bif.in_service, 4'b1000);

    // nesting, then a spurious acknowledge
    do_reset();
    set_base(8'h40);
    raise(2);
    sb.push_back(8'h44);
    do_ack("nest a2");
    raise(0);
    check("nest nINT", bif.nINT, 0);
    sb.push_back(8'h40);
    do_ack("nest a0");
    check("nest isv", bif.in_service, 4'b0101);
    reti();
    check("nest reti1", bif.in_service, 4'b0100);
    reti();
    check("nest reti2", bif.in_service, 0);
    raise(1);
    sb.push_back(8'h42);
    do_ack("nest a1");
    sb.push_back(8'hFF);
    do_ack("spur");
    check("spur isv", bif.in_service, 4'b0010);
    check("spur pend", bif.pending, 0);

    // RETI decoding corner cases
    do_reset();
    set_base(8'h00);
    raise(2);
    sb.push_back(8'h04);
    do_ack("rd a2");
    raise(1);
    sb.push_back(8'h02);
    do_ack("rd a1");
    check("rd isv", bif.in_service, 4'b0110);
    fetch(8'hED); fetch(8'h00); fetch(8'h4D);
    check("rd ed00_4d", bif.in_service, 4'b0110);
    io_read(8'hED); fetch(8'h4D);
    check("rd io_ed", bif.in_service, 4'b0110);
    fetch(8'hED); fetch(8'hED); fetch(8'h4D);
    check("rd eded4d", bif.in_service, 4'b0100);
    fetch(8'hED); io_read(8'h00); fetch(8'h4D);
    check("rd io_noreset", bif.in_service, 4'b0000);

    // vector frozen against a base write, then async reset during the held ack
    do_reset();
    set_base(8'h40);
    bif.irq_req = 4'b0011;
    tick(); tick();
    bif.nM1 = 1'b0; bif.nIORQ = 1'b0;
    tick();
    check("rst_ack oe", bif.db_oe, 1);
    check("rst_ack vec", bif.db_out, 8'h40);
    bif.cfg_we = 1'b1; bif.cfg_data = 8'hA0;
    tick();
    bif.cfg_we = 1'b0;
    tick();
    check("rst_ack frozen", bif.db_out, 8'h40);
    check("rst_ack pend", bif.pending, 4'b0010);
    #2;
    nreset = 1'b0;
    #1;
    check("rst_ack oe0", bif.db_oe, 0);
    check("rst_ack nINT", bif.nINT, 1);
    check("rst_ack pend0", bif.pending, 0);
    check("rst_ack isv0", bif.in_service, 0);
    idle_bus();
    bif.irq_req = '0;
    tick();
    nreset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
